// File: rtl/ecc_scalar_mul_ctrl_if.sv
// ecc_scalar_mul_ctrl_if: host request/status and shared modular-ALU handshake bundle
interface ecc_scalar_mul_ctrl_if #(
    parameter int SCALAR_W = 255
);
    logic                start;
    logic [SCALAR_W-1:0] scalar;
    logic                busy;
    logic                done;
    logic                err;
    logic [2:0]          phase;
    logic                alu_in_valid;
    logic [1:0]          alu_in_state;
    logic                alu_keep_flag;
    logic                alu_consecutive_flag;
    logic                alu_out_ready;

    modport master (
        input  start, scalar, alu_out_ready,
        output busy, done, err, phase, alu_in_valid, alu_in_state, alu_keep_flag, alu_consecutive_flag
    );

    modport slave (
        output start, scalar, alu_out_ready,
        input  busy, done, err, phase, alu_in_valid, alu_in_state, alu_keep_flag, alu_consecutive_flag
    );
endinterface

// File: rtl/ecc_scalar_mul_ctrl.sv
// ecc_scalar_mul_ctrl: sequences PRE, MSB-first double-and-add ladder, Fermat inversion and DIVMUL on the shared ALU with a per-op watchdog; ECC_SKIP_LEADING_ZERO_EN starts the ladder at the scalar's highest set bit
module ecc_scalar_mul_ctrl #(
    parameter int               SCALAR_W = 255,
    parameter int               INV_W    = 255,
    parameter logic [INV_W-1:0] INV_EXP  = {INV_W{1'b1}} - INV_W'(20),
    parameter int               TIMEOUT  = 15
) (
    input logic                   clk,
    input logic                   rst,
    ecc_scalar_mul_ctrl_if.master bus
);
    localparam int BW = SCALAR_W > 1 ? $clog2(SCALAR_W) : 1;
    localparam int EW = INV_W > 1 ? $clog2(INV_W) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PRE, LADDER, INV, DMUL, DONE} state_e;

    state_e              state_q, state_d;
    logic [SCALAR_W-1:0] k_q, k_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d, start_idx;
    logic [EW-1:0]       exp_idx_q, exp_idx_d;
    logic                cons_q, cons_d, keep_q, keep_d, launch_q, launch_d;
    logic [WW-1:0]       wd_q, wd_d;
    logic                busy, wd_exp, skip_ladder;

    assign busy   = state_q inside {PRE, LADDER, INV, DMUL};
    assign wd_exp = busy && !bus.alu_out_ready && wd_q == WW'(TIMEOUT - 1);

`ifdef ECC_SKIP_LEADING_ZERO_EN
    // ladder starts at the highest set bit so leading zeros are never doubled
    always_comb begin
        start_idx = '0;
        for (int i = 0; i < SCALAR_W; i++) if (bus.scalar[i]) start_idx = BW'(i);
    end
    assign skip_ladder = k_q == '0;
`else
    assign start_idx   = BW'(SCALAR_W - 1);
    assign skip_ladder = 1'b0;
`endif

    // state and datapath registers, async active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            bit_idx_q <= '0;
            exp_idx_q <= '0;
            cons_q    <= 1'b0;
            keep_q    <= 1'b0;
            launch_q  <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            bit_idx_q <= bit_idx_d;
            exp_idx_q <= exp_idx_d;
            cons_q    <= cons_d;
            keep_q    <= keep_d;
            launch_q  <= launch_d;
            wd_q      <= wd_d;
        end
    end

    // next state; flags move on each out_ready so the chained op sees them from its first cycle
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        bit_idx_d = bit_idx_q;
        exp_idx_d = exp_idx_q;
        cons_d    = cons_q;
        keep_d    = keep_q;
        launch_d  = 1'b0;
        wd_d      = (busy && !launch_q && !bus.alu_out_ready) ? wd_q + 1'b1 : '0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d   = PRE;
                k_d       = bus.scalar;
                bit_idx_d = start_idx;
                launch_d  = 1'b1;
            end
            PRE: if (bus.alu_out_ready) begin
                state_d  = skip_ladder ? INV : LADDER;
                launch_d = 1'b1;
                cons_d   = k_q[bit_idx_q];
                keep_d   = bit_idx_q != '0;
            end
            LADDER: if (bus.alu_out_ready) begin
                if (bit_idx_q == '0) begin
                    state_d  = INV;
                    launch_d = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                    cons_d    = k_q[bit_idx_d];
                    keep_d    = bit_idx_d != '0;
                end
            end
            INV: if (bus.alu_out_ready) begin
                if (exp_idx_q == '0) begin
                    state_d  = DMUL;
                    launch_d = 1'b1;
                    cons_d   = 1'b0;
                    keep_d   = 1'b0;
                end else begin
                    exp_idx_d = exp_idx_q - 1'b1;
                    cons_d    = INV_EXP[exp_idx_d];
                    keep_d    = exp_idx_d != '0;
                end
            end
            DMUL: if (bus.alu_out_ready) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (state_d == INV && state_q != INV) begin
            exp_idx_d = EW'(INV_W - 1);
            cons_d    = INV_EXP[INV_W-1];
            keep_d    = INV_W > 1;
        end
        if (wd_exp) begin
            state_d  = IDLE;
            launch_d = 1'b0;
            cons_d   = 1'b0;
            keep_d   = 1'b0;
        end
    end

    // outputs decoded from registered state; err fires on the cycle the watchdog expires
    always_comb begin
        bus.phase                = state_q;
        bus.busy                 = busy;
        bus.done                 = state_q == DONE;
        bus.err                  = wd_exp;
        bus.alu_in_valid         = launch_q;
        bus.alu_in_state         = state_q == LADDER ? 2'd1 : state_q == INV ? 2'd2 : state_q == DMUL ? 2'd3 : 2'd0;
        bus.alu_keep_flag        = keep_q;
        bus.alu_consecutive_flag = cons_q;
    end
endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// tb_ecc_scalar_mul_ctrl: scoreboard bench with a behavioural ALU for the 4-bit controller build
module tb_ecc_scalar_mul_ctrl;
    localparam int         TIMEOUT = 15;
    localparam logic [3:0] INV_E   = 4'b1011;
    localparam logic [1:0] K_L = 2'd0, K_R = 2'd1, K_D = 2'd2, K_E = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] st;
        logic       c;
        logic       k;
    } ev_t;

    logic  clk = 1'b0;
    logic  rst;
    bit    stall_inv = 1'b0;
    int    checks = 0, errors = 0, cyc = 0, last_evt = 0, done_n = 0;
    ev_t   exp_q[$];
    logic [10:0] outs;

    ecc_scalar_mul_ctrl_if #(.SCALAR_W(4)) bus ();

    ecc_scalar_mul_ctrl #(
        .SCALAR_W(4),
        .INV_W   (4),
        .INV_EXP (INV_E),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign outs = {bus.busy, bus.done, bus.err, bus.phase, bus.alu_in_valid, bus.alu_in_state,
                   bus.alu_keep_flag, bus.alu_consecutive_flag};

    function automatic ev_t mk(input logic [1:0] kd, input logic [1:0] st, input logic c, input logic k);
        return {kd, st, c, k};
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic cmp_ev(input ev_t g, input string nm);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got kind=%0d state=%0d cons=%0d keep=%0d expected no event", nm, g.kind, g.st, g.c, g.k);
        end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got kind=%0d state=%0d cons=%0d keep=%0d expected kind=%0d state=%0d cons=%0d keep=%0d",
                         nm, g.kind, g.st, g.c, g.k, e.kind, e.st, e.c, e.k);
            end
        end
    endtask

    task automatic push_seq(input logic [3:0] s, input bit stall);
        logic [3:0] e;
        int         top;
        bit         lad;
        e   = INV_E;
        top = 3;
        lad = 1'b1;
`ifdef ECC_SKIP_LEADING_ZERO_EN
        lad = s != 4'd0;
        for (int i = 0; i < 4; i++) if (s[i]) top = i;
`endif
        exp_q.push_back(mk(K_L, 2'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(K_R, 2'd0, 1'b0, 1'b0));
        if (lad) begin
            exp_q.push_back(mk(K_L, 2'd1, s[top], top != 0));
            for (int i = top; i >= 0; i--) exp_q.push_back(mk(K_R, 2'd1, s[i], i != 0));
        end
        exp_q.push_back(mk(K_L, 2'd2, e[3], 1'b1));
        if (stall) begin
            exp_q.push_back(mk(K_R, 2'd2, e[3], 1'b1));
            exp_q.push_back(mk(K_E, 2'd0, 1'b0, 1'b0));
        end else begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(mk(K_R, 2'd2, e[i], i != 0));
            exp_q.push_back(mk(K_L, 2'd3, 1'b0, 1'b0));
            exp_q.push_back(mk(K_R, 2'd3, 1'b0, 1'b0));
            exp_q.push_back(mk(K_D, 2'd0, 1'b0, 1'b0));
        end
    endtask

    task automatic start_seq(input logic [3:0] s, input bit stall);
        push_seq(s, stall);
        bus.scalar = s;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // sel: 0 done, 1 err, 2 phase LADDER
    task automatic wait_for(input int sel, input int lim, input string nm);
        int n = 0;
        while (!(sel == 0 ? bus.done : sel == 1 ? bus.err : bus.phase == 3'd2) && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL %s: got no event within %0d cycles, expected event", nm, n);
        end
    endtask

    function automatic int dur(input logic [1:0] st, input logic c);
        return st == 2'd0 ? 6 : st == 2'd1 ? (c ? 14 : 8) : st == 2'd2 ? (c ? 12 : 6) : 5;
    endfunction

    initial begin : alu_model
        int rem, inv_n;
        bit act, chain;
        rem = 0; inv_n = 0; act = 1'b0; chain = 1'b0;
        bus.alu_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.alu_out_ready = 1'b0;
            if (!rst || bus.phase == 3'd0) begin
                act   = 1'b0;
                chain = 1'b0;
            end else if (bus.alu_in_valid) begin
                act   = 1'b1;
                rem   = dur(bus.alu_in_state, bus.alu_consecutive_flag);
                inv_n = 0;
            end else if (chain) begin
                chain = 1'b0;
                act   = 1'b1;
                rem   = dur(bus.alu_in_state, bus.alu_consecutive_flag) - 1;
            end else if (act) begin
                rem--;
            end
            if (act && rem <= 0 && !(stall_inv && bus.alu_in_state == 2'd2 && inv_n > 0)) begin
                bus.alu_out_ready = 1'b1;
                act   = 1'b0;
                chain = bus.alu_keep_flag;
                if (bus.alu_in_state == 2'd2) inv_n++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus.alu_in_valid) begin
                cmp_ev(mk(K_L, bus.alu_in_state, bus.alu_consecutive_flag, bus.alu_keep_flag), "launch");
                last_evt = cyc;
            end
            if (bus.alu_out_ready) begin
                cmp_ev(mk(K_R, bus.alu_in_state, bus.alu_consecutive_flag, bus.alu_keep_flag), "out_ready_flags");
                last_evt = cyc;
            end
            if (bus.done) begin
                cmp_ev(mk(K_D, 2'd0, 1'b0, 1'b0), "done");
                chk("done_latency", cyc - last_evt, 1);
                chk("busy_in_done", int'(bus.busy), 0);
                done_n++;
            end
            if (bus.err) begin
                cmp_ev(mk(K_E, 2'd0, 1'b0, 1'b0), "err");
                chk("err_latency", cyc - last_evt, TIMEOUT);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench hung");
    end

    initial begin
        int n, d0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.scalar = 4'd0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(outs), 0);
        rst = 1'b1;
        @(negedge clk);

        start_seq(4'b1010, 1'b0);
        wait_for(0, 400, "done_1010");
        repeat (3) @(negedge clk);
        chk("queue_1010", exp_q.size(), 0);

        start_seq(4'b0000, 1'b0);
        wait_for(0, 400, "done_0000");
        repeat (3) @(negedge clk);
        chk("queue_0000", exp_q.size(), 0);

        start_seq(4'b1010, 1'b0);
        wait_for(2, 100, "ladder_1010");
        repeat (3) @(negedge clk);
        bus.scalar = 4'b0101;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_for(0, 400, "done_start_while_busy");
        repeat (3) @(negedge clk);
        chk("queue_start_while_busy", exp_q.size(), 0);

        stall_inv = 1'b1;
        start_seq(4'b0110, 1'b1);
        wait_for(1, 400, "err_0110");
        stall_inv = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_after_err", int'(bus.busy), 0);
        chk("done_after_err", int'(bus.done), 0);
        chk("phase_after_err", int'(bus.phase), 0);
        chk("queue_err", exp_q.size(), 0);

        start_seq(4'b1101, 1'b0);
        wait_for(2, 100, "ladder_1101");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("async_reset_outputs", int'(outs), 0);
        exp_q.delete();
        @(negedge clk);
        chk("reset_held_outputs", int'(outs), 0);
        rst = 1'b1;
        @(negedge clk);
        start_seq(4'b1101, 1'b0);
        wait_for(0, 400, "done_after_reset");
        repeat (3) @(negedge clk);
        chk("queue_after_reset", exp_q.size(), 0);

        d0 = done_n;
        push_seq(4'b0011, 1'b0);
        push_seq(4'b0011, 1'b0);
        bus.scalar = 4'b0011;
        bus.start  = 1'b1;
        wait_for(0, 400, "done_b2b_first");
        n = 0;
        while (!bus.alu_in_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_relaunch_cycles", n, 2);
        bus.start = 1'b0;
        wait_for(0, 400, "done_b2b_second");
        repeat (20) @(negedge clk);
        chk("b2b_done_count", done_n - d0, 2);
        chk("queue_b2b", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
